// File: rtl/rx_read_ctrl.sv
// rx_read_ctrl: drains an Rx FIFO one byte at a time into a valid/ready
// consumer port, counts delivered bytes, raises an idle-timeout pulse and
// keeps a sticky "FIFO was full" status bit.
module rx_read_ctrl #(
    parameter int FIFO_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr_status,
    input  logic                  rx_empty,
    input  logic                  rx_full,
    input  logic [FIFO_WIDTH-1:0] read_data,
    output logic                  ren,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  irq_timeout,
    output logic                  full_seen,
    output logic [CNT_WIDTH-1:0]  byte_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [15:0]           tcnt_q, tcnt_d;
    logic                  armed_q, armed_d;
    logic                  irq_q, irq_d;
    logic                  full_q, full_d;
    logic                  sync1_q, sync2_q;
    // Set one edge after reset release so the first read strobe cannot
    // appear before the second clock edge.
    logic                  live_q;
    logic                  handshake;

    assign handshake = (state_q == S_OUT) && m_ready;

    // Read sequencing FSM, output byte capture and delivered-byte counter.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (live_q && enable && !rx_empty) state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_OUT;
                data_d  = read_data;
            end
            default: begin
                if (m_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (enable && !rx_empty) ? S_ISSUE : S_IDLE;
                end
            end
        endcase
    end

    // Idle timeout: armed by each handshake, counts idle-empty cycles,
    // fires once and disarms until the next handshake.
    always_comb begin
        irq_d   = 1'b0;
        armed_d = armed_q;
        tcnt_d  = tcnt_q;
        if (handshake) begin
            armed_d = 1'b1;
            tcnt_d  = '0;
        end else if ((state_q == S_IDLE) && rx_empty && armed_q) begin
            if (tcnt_q == TO_LAST) begin
                irq_d   = 1'b1;
                tcnt_d  = '0;
                armed_d = 1'b0;
            end else begin
                tcnt_d = tcnt_q + 16'd1;
            end
        end else begin
            tcnt_d = '0;
        end
    end

    // Sticky full status: a synchronized full overrides a same-cycle clear.
    always_comb begin
        full_d = sync2_q | (full_q & ~clr_status);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            armed_q <= 1'b0;
            irq_q   <= 1'b0;
            full_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            armed_q <= armed_d;
            irq_q   <= irq_d;
            full_q  <= full_d;
            sync1_q <= rx_full;
            sync2_q <= sync1_q;
            live_q  <= 1'b1;
        end
    end

    assign ren         = (state_q == S_ISSUE);
    assign m_valid     = (state_q == S_OUT);
    assign m_data      = data_q;
    assign irq_timeout = irq_q;
    assign full_seen   = full_q;
    assign byte_cnt    = cnt_q;

endmodule

// File: tb/tb_rx_read_ctrl.sv
// Directed testbench for rx_read_ctrl with a small behavioural Rx FIFO.
module tb_rx_read_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clr_status;
    logic        rx_empty;
    logic        rx_full;
    logic [7:0]  read_data = '0;
    logic        ren;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        irq_timeout;
    logic        full_seen;
    logic [15:0] byte_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: data appears one clock after a sampled ren.
    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr = '0;
    logic [3:0] rd_ptr = '0;

    assign rx_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (ren && !rx_empty) begin
            read_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
        end
    end

    always #5 clk = ~clk;

    rx_read_ctrl #(
        .FIFO_WIDTH    (8),
        .TIMEOUT_CYCLES(8),
        .CNT_WIDTH     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clr_status (clr_status),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .read_data  (read_data),
        .ren        (ren),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .irq_timeout(irq_timeout),
        .full_seen  (full_seen),
        .byte_cnt   (byte_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 4'd1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int pulses;

    initial begin
        rst        = 1'b0;
        enable     = 1'b0;
        clr_status = 1'b0;
        rx_full    = 1'b0;
        m_ready    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ren",      ren,         0);
        chk("rst_mvalid",   m_valid,     0);
        chk("rst_mdata",    m_data,      0);
        chk("rst_irq",      irq_timeout, 0);
        chk("rst_full",     full_seen,   0);
        chk("rst_cnt",      byte_cnt,    0);

        // Single byte 0xA5, FIFO loaded before reset release
        push(8'hA5);
        enable  = 1'b1;
        m_ready = 1'b1;
        rst     = 1'b1;
        step();
        chk("rel_no_ren",   ren,     0);
        step();
        chk("sb_ren",       ren,     1);
        step();
        chk("sb_ren_off",   ren,     0);
        chk("sb_wait_mv",   m_valid, 0);
        step();
        chk("sb_mvalid",    m_valid, 1);
        chk("sb_mdata",     m_data,  8'hA5);
        step();
        chk("sb_mv_off",    m_valid, 0);
        chk("sb_cnt",       byte_cnt, 1);

        // Timeout: pulse 8 cycles after the handshake, exactly once
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_early", irq_timeout, 0);
        end
        step();
        chk("to_pulse",     irq_timeout, 1);
        step();
        chk("to_one_cyc",   irq_timeout, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (irq_timeout) pulses++;
        end
        chk("to_no_second", pulses, 0);

        // Backpressure: three bytes, consumer stalled for 10 cycles
        m_ready = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        step();
        chk("bp_ren",       ren, 1);
        step();
        step();
        chk("bp_mv11",      m_valid, 1);
        chk("bp_d11",       m_data,  8'h11);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_mv",  m_valid, 1);
            chk("bp_hold_d",   m_data,  8'h11);
            chk("bp_hold_ren", ren,     0);
        end
        m_ready = 1'b1;
        step();
        chk("bp_ren2",      ren,     1);
        chk("bp_mv_gap",    m_valid, 0);
        step();
        step();
        chk("bp_mv22",      m_valid, 1);
        chk("bp_d22",       m_data,  8'h22);
        step();
        chk("bp_ren3",      ren, 1);
        step();
        step();
        chk("bp_mv33",      m_valid, 1);
        chk("bp_d33",       m_data,  8'h33);
        step();
        chk("bp_end_mv",    m_valid, 0);
        chk("bp_end_ren",   ren,     0);
        chk("bp_cnt",       byte_cnt, 4);

        // Enable drop during WAIT with data left in the FIFO
        push(8'h44);
        push(8'h55);
        step();
        chk("ed_ren",       ren, 1);
        step();
        chk("ed_wait_ren",  ren, 0);
        enable = 1'b0;
        step();
        chk("ed_mv",        m_valid, 1);
        chk("ed_d44",       m_data,  8'h44);
        step();
        chk("ed_mv_off",    m_valid, 0);
        chk("ed_cnt",       byte_cnt, 5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ed_idle_ren", ren,     0);
            chk("ed_idle_mv",  m_valid, 0);
        end
        enable = 1'b1;
        step();
        chk("ed_resume",    ren, 1);
        step();
        step();
        chk("ed_d55",       m_data, 8'h55);
        step();
        chk("ed_cnt2",      byte_cnt, 6);

        // full_seen: set through synchronizer, clear, set-wins-over-clear
        rx_full = 1'b1;
        step();
        rx_full = 1'b0;
        step();
        step();
        chk("fs_set",       full_seen, 1);
        step();
        chk("fs_sticky",    full_seen, 1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("fs_clr",       full_seen, 0);
        rx_full = 1'b1;
        step();
        rx_full = 1'b0;
        step();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("fs_set_wins",  full_seen, 1);
        step();
        chk("fs_after_win", full_seen, 1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("fs_clr2",      full_seen, 0);

        // Reset asserted while a byte is presented
        m_ready = 1'b0;
        push(8'h66);
        step();
        chk("rm_ren",       ren, 1);
        step();
        step();
        chk("rm_mv",        m_valid, 1);
        chk("rm_d66",       m_data,  8'h66);
        #2 rst = 1'b0;
        #1;
        chk("rm_ren0",      ren,         0);
        chk("rm_mv0",       m_valid,     0);
        chk("rm_d0",        m_data,      0);
        chk("rm_irq0",      irq_timeout, 0);
        chk("rm_full0",     full_seen,   0);
        chk("rm_cnt0",      byte_cnt,    0);
        step();
        rst     = 1'b1;
        m_ready = 1'b1;
        repeat (4) step();
        chk("rm_cnt_after", byte_cnt, 0);
        chk("rm_mv_after",  m_valid,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
